// File: rtl/byte_serial_add_seq.sv
// Byte-serial multi-precision add/subtract sequencer around an external 8-bit adder.
// Latency: one clk from operand accept to the result byte on out_sum.
// Backpressure: single output register with no skid; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   in_valid/in_ready                operand beat stream, LSB byte first
//   in_a, in_b, in_sub               operand bytes; in_sub is sampled on the first beat only
//   adder_a/adder_b/adder_cin        combinational drive to the external adder
//   adder_sum/adder_cout             external adder results, registered on accept
//   out_valid/out_ready              result byte stream
//   out_sum, out_last                result byte and final-byte marker
//   out_cout, out_ovf                final carry (1 = no borrow on subtract) and signed overflow,
//                                    both forced to 0 on non-last bytes
module byte_serial_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_sub,
  output logic [7:0] adder_a,
  output logic [7:0] adder_b,
  output logic       adder_cin,
  input  logic [7:0] adder_sum,
  input  logic       adder_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_cout,
  output logic       out_ovf
);

  // Counter is at least one bit wide so NBYTES==1 still elaborates cleanly.
  localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,  // next accepted beat starts a new operation
    BUSY = 1'b1   // mid-operation, carry chained from previous beat
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          carry_q;
  logic          sub_q;

  logic          accept;
  logic          sub_eff;
  logic          is_last;
  logic          ovf_now;

  // ---------------------------------------------------------------------------
  // Adder drive. On the first beat the operation type comes straight from
  // in_sub (it is not registered yet); afterwards the latched sub_q is used so
  // in_sub toggling mid-operation has no effect.
  // ---------------------------------------------------------------------------
  assign sub_eff   = (state == IDLE) ? in_sub : sub_q;
  assign adder_a   = in_a;
  assign adder_b   = sub_eff ? ~in_b : in_b;
  // Subtract is A + ~B + 1, so the first beat injects in_sub as carry-in.
  assign adder_cin = (state == IDLE) ? in_sub : carry_q;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // cnt is 0 in IDLE, so this also covers NBYTES==1 where every beat is last.
  assign is_last   = (cnt == LAST);

  // Signed overflow: operands agree in sign (after B inversion) but the sum
  // does not.
  assign ovf_now   = (adder_a[7] == adder_b[7]) && (adder_sum[7] != adder_a[7]);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and byte counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (NBYTES > 1) begin
            state_d = BUSY;
            cnt_d   = CW'(1);
          end
        end
        BUSY: begin
          if (is_last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Carry chain and operation type. The carry is cleared on the last beat so
  // nothing can leak into the next operation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else if (accept) begin
      carry_q <= is_last ? 1'b0 : adder_cout;
      if (state == IDLE) begin
        sub_q <= in_sub;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. A consume without a new accept only drops out_valid; the
  // data and flags hold their last values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= 8'h00;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= adder_sum;
      out_last  <= is_last;
      out_cout  <= is_last ? adder_cout : 1'b0;
      out_ovf   <= is_last ? ovf_now : 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_serial_add_seq.sv
module tb_byte_serial_add_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_sub;
  logic [7:0] adder_a;
  logic [7:0] adder_b;
  logic       adder_cin;
  logic [7:0] adder_sum;
  logic       adder_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_last;
  logic       out_cout;
  logic       out_ovf;

  int errs;
  int checks;

  byte_serial_add_seq #(.NBYTES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_last   (out_last),
    .out_cout   (out_cout),
    .out_ovf    (out_ovf)
  );

  // External 8-bit ripple-carry adder stage.
  logic [8:0] add_full;
  assign add_full   = {1'b0, adder_a} + {1'b0, adder_b} + {8'h00, adder_cin};
  assign adder_sum  = add_full[7:0];
  assign adder_cout = add_full[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat, let it be accepted on the next edge, then check the
  // registered result byte and flags.
  task automatic beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [7:0] es, input logic el,
                      input logic ec, input logic eo);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = s;
    @(posedge clk);
    #1;
    chk({tag, ".vld"},  out_valid, 1);
    chk({tag, ".sum"},  out_sum,   es);
    chk({tag, ".last"}, out_last,  el);
    chk({tag, ".cout"}, out_cout,  ec);
    chk({tag, ".ovf"},  out_ovf,   eo);
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_sub    = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst.vld",   out_valid, 0);
    chk("rst.rdy",   in_ready,  1);
    chk("rst.sum",   out_sum,   0);
    chk("rst.last",  out_last,  0);
    chk("rst.cout",  out_cout,  0);
    chk("rst.ovf",   out_ovf,   0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1. 0x000000FF + 0x00000001, followed immediately by
    // 2. 0x00000000 - 0x00000001 with no idle cycle between operations.
    beat("add1.b0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("add1.b1", 8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    beat("add1.b2", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("add1.b3", 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    in_a = 8'h00; in_b = 8'h01; in_sub = 1'b1;
    #1;
    chk("sub.cin0", adder_cin, 1);
    chk("sub.b0",   adder_b,   8'hFE);
    beat("sub.b0", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    beat("sub.b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    beat("sub.b2", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    beat("sub.b3", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // 4. 0xFFFFFFFF + 0xFFFFFFFF ends with carry 1; 3. follows back-to-back,
    // so a leaked carry would turn its first byte into 01.
    beat("cy.b0", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    beat("cy.b1", 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    beat("cy.b2", 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    beat("cy.b3", 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);

    in_a = 8'hFF; in_b = 8'h01; in_sub = 1'b0;
    #1;
    chk("ovf.cin0", adder_cin, 0);
    beat("ovf.b0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("ovf.b1", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("ovf.b2", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("ovf.b3", 8'h7F, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);

    // Idle: a consume with no new beat drops out_valid, data holds.
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain.vld",  out_valid, 0);
    chk("drain.sum",  out_sum,   8'h80);
    chk("drain.ovf",  out_ovf,   1);

    // 5. 0x01020304 + 0x10203040 with backpressure after beat 2 and in_sub
    // raised on beat 3 (must be ignored).
    beat("bp.b0", 8'h04, 8'h40, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);
    beat("bp.b1", 8'h03, 8'h30, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h02;
    in_b      = 8'h20;
    in_sub    = 1'b1;
    #1;
    chk("bp.rdy",   in_ready, 0);
    chk("bp.addb",  adder_b,  8'h20);
    chk("bp.cin",   adder_cin, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp.hold.vld", out_valid, 1);
      chk("bp.hold.sum", out_sum,   8'h33);
      chk("bp.hold.rdy", in_ready,  0);
    end
    out_ready = 1'b1;
    beat("bp.b2", 8'h02, 8'h20, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    beat("bp.b3", 8'h01, 8'h10, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);

    // 6. Reset after two beats that leave a pending carry.
    beat("rs.b0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("rs.b1", 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rs.vld", out_valid, 0);
    chk("rs.rdy", in_ready,  1);
    chk("rs.sum", out_sum,   0);
    chk("rs.last", out_last, 0);
    #2;
    rst_n  = 1'b1;
    in_a   = 8'h10;
    in_b   = 8'h20;
    in_sub = 1'b0;
    #1;
    chk("rs.cin", adder_cin, 0);
    beat("rs.n0", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    beat("rs.n1", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("rs.n2", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    beat("rs.n3", 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("end.vld", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/byte_serial_add_seq.md
# byte_serial_add_seq

Byte-serial multi-precision add/subtract sequencer that sits directly around the 8-bit ripple-carry adder stage.

- **Upstream role:** accepts operand byte pairs over a valid/ready stream and drives the adder's A/B/Cin inputs.
- **Downstream role:** registers the adder's Sum/Cout, chaining the carry between beats to build NBYTES-wide results LSB-first.
- **Output:** result bytes go out on a valid/ready stream, with final carry and signed-overflow flags on the last byte.

## Interface
- NBYTES, 4, operand width in bytes; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- in_a  in  8  operand A byte, LSB byte first.
- in_b  in  8  operand B byte.
- in_sub  in  1  1 = A−B, 0 = A+B; sampled on first beat of an operation only.
- adder_a  out  8  to adder A.
- adder_b  out  8  to adder B.
- adder_cin  out  1  to adder Cin.
- adder_sum  in  8  from adder Sum.
- adder_cout  in  1  from adder Cout.
- out_valid  out  1  result byte valid.
- out_ready  in  1  result byte consumed when out_valid && out_ready.
- out_sum  out  8  result byte.
- out_last  out  1  marks the final (MSB) byte of an operation.
- out_cout  out  1  final carry; 0 unless out_last.
- out_ovf  out  1  signed two's-complement overflow; 0 unless out_last.

## Operation

**State machine and counter**
- FSM states: IDLE (next beat is first), BUSY (mid-operation).
- Byte counter cnt, 0..NBYTES−1.

**Adder drive (combinational)**
- adder_a = in_a.
- adder_b = sub_eff ? ~in_b : in_b.
- adder_cin = (state==IDLE) ? in_sub : carry_q.
- sub_eff = in_sub in IDLE, sub_q in BUSY.

**Handshake**
- in_ready = !out_valid || out_ready (single output register, no skid).

**On accept**
- out_sum ← adder_sum, carry_q ← adder_cout.
- out_last ← (cnt==NBYTES−1).
- out_valid ← 1.
- In IDLE, additionally sub_q ← in_sub.

**Transitions on accept**
- IDLE with NBYTES==1: stay IDLE; every beat is both first and last.
- IDLE with NBYTES>1: go to BUSY, cnt ← 1.
- BUSY with cnt==NBYTES−1: go to IDLE, cnt ← 0, carry_q ← 0.
- BUSY otherwise: cnt ← cnt+1.

**Last-byte flags**
- out_cout ← adder_cout. For subtract, 1 means no borrow.
- out_ovf ← (adder_a[7]==adder_b[7]) && (adder_sum[7]!=adder_a[7]), evaluated on the post-inversion adder_b.
- On non-last bytes, out_cout = out_ovf = 0.

**Output register**
- Without accept: if out_ready is high, out_valid ← 0; out_sum, out_last and the flags hold their values.
- in_sub on non-first beats is ignored.
- Width is fixed at 8 bits per beat; all arithmetic is modulo 2^(8·NBYTES).

## Timing

**Reset values (asynchronous)**
- state = IDLE, cnt = 0, carry_q = 0, sub_q = 0.
- out_valid = 0, out_sum = 0x00, out_last = 0, out_cout = 0, out_ovf = 0.
- in_ready = 1.

**Reset mid-operation**
- Discards the partial result and any pending out_valid.
- The first accepted beat after rst_n deasserts is treated as a first beat.

**Latency and throughput**
- Latency: result byte appears on out_sum one clk after the accept.
- Throughput: one beat per cycle while out_ready stays high.

**Backpressure**
- With out_valid=1 and out_ready=0: in_ready=0, all outputs hold, carry_q and cnt hold.
- Simultaneous consume and accept in the same cycle is legal; out_valid stays 1 with the new byte.

**Boundary conditions**
- Adder path is combinational, so adder_* must settle within one cycle.
- After the last beat, the next operation's first beat may be accepted on the very next cycle.
- carry_q never leaks between operations.

## Test plan
1. **Basic add with carry chain.** NBYTES=4, add 0x000000FF + 0x00000001 as beats (FF,01),(00,00),(00,00),(00,00) -> out_sum 00,01,00,00; out_last only on 4th byte; out_cout=0, out_ovf=0.
2. **Subtract with borrow.** Sub 0x00000000 − 0x00000001 -> FF,FF,FF,FF; out_cout=0 (borrow), out_ovf=0; adder_cin=1 on first beat.
3. **Signed overflow.** Add 0x7FFFFFFF + 0x00000001 -> 00,00,00,80; out_ovf=1, out_cout=0.
4. **Unsigned carry-out.** Add 0xFFFFFFFF + 0xFFFFFFFF -> FE,FF,FF,FF; out_cout=1, out_ovf=0.
5. **Backpressure and sub-flag sampling.**
   - Hold out_ready=0 for 3 cycles after beat 2 -> in_ready=0, out_sum holds, result unchanged after release.
   - Toggle in_sub on beat 3 -> ignored.
6. **Reset mid-operation.** Assert rst_n=0 after beat 2 of an add -> all outputs reach reset values immediately. Next beat (10,20,in_sub=0) is treated as first: adder_cin=0, out_sum=30.
